serial_word_collector: RTL and testbench
========================================

Name: serial_word_collector

Overview:
Serial-to-parallel receive end of the team's MSB-first shift-out path. Each accepted bit is shifted into a WIDTH-bit register, MSB first. After WIDTH bits, the block presents the assembled word on a valid/ready output port. It sits between a serial link and the word-level consumer logic and tracks frame progress, overrun and, optionally, parity.

Parameters:
WIDTH, 16, word length in bits (≥2)
CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  sole clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle pulse; opens a new frame (aborts any frame in progress)
bit_valid  input  1  strobe: bit_in is sampled this cycle
bit_in  input  1  serial data bit, MSB of word first
data_out  output  WIDTH  assembled word, stable while out_valid=1
out_valid  output  1  word available
out_ready  input  1  consumer accepts word when out_valid&out_ready
busy  output  1  high in SHIFT (and PARITY) states
bit_count  output  CNT_W  bits received in current frame
overrun  output  1  sticky: bit arrived while a word was unconsumed
parity_err  output  1  parity mismatch on held word (0 when feature disabled)

Behaviour:
- Reset (rst=1 at clk edge), highest priority, any state: state=IDLE, shreg=0, data_out=0, out_valid=0, busy=0, bit_count=0, overrun=0, parity_err=0.
- States: IDLE, SHIFT, PARITY (feature only), HOLD.
- IDLE:
  - start=1 -> SHIFT, shreg=0, bit_count=0, overrun=0.
  - bit_valid is ignored, including on the start cycle.
- SHIFT:
  - bit_valid=1 -> shreg <= {shreg[WIDTH-2:0], bit_in}, bit_count++.
  - On the bit_valid where bit_count==WIDTH-1:
    - without feature: data_out <= final word, out_valid=1 next cycle, go to HOLD, bit_count=WIDTH.
    - with feature: go to PARITY.
  - bit_valid=0 -> hold state.
- start in SHIFT/PARITY: abort and restart. shreg=0, bit_count=0, stay/return SHIFT; the bit on that cycle is dropped. No word is emitted for the aborted frame.
- HOLD:
  - out_valid=1 and data_out held constant.
  - out_ready=1 -> out_valid=0 next cycle, then:
    - start also 1 -> SHIFT (fresh frame, overrun cleared);
    - else -> IDLE.
  - bit_valid=1 in HOLD -> overrun=1 (sticky), bit discarded, data_out unchanged.
  - start without out_ready in HOLD: ignored (word is never lost).
- overrun clears only on rst or on an accepted start.
- Latency: out_valid rises on the first edge after the final data bit (or the parity bit) is sampled. Minimum frame time is WIDTH cycles with bit_valid held high.
- bit_count saturates at WIDTH in HOLD. busy is a combinational decode of state.

Optional Feature:
Macro PARITY_EN.
- Defined:
  - After WIDTH data bits, state PARITY waits for one more bit_valid. That bit is the even-parity bit over the data word.
  - On sampling it: data_out loaded, out_valid=1, parity_err = (^word) ^ parity_bit, go to HOLD.
  - parity_err is valid while out_valid=1 and clears when the word is accepted.
- Undefined: no PARITY state; parity_err tied 0; frame is exactly WIDTH bits.

Test Plan:
- rst, start, then 16 consecutive bit_valid bits of 0xA5C3 MSB-first, out_ready=1 -> out_valid on cycle after 16th bit, data_out=0xA5C3, accepted next cycle, back to IDLE, busy=0.
- Frame 0x8001 with bit_valid gapped every other cycle, out_ready=0 for 5 cycles -> out_valid and data_out=0x8001 held stable 5 cycles, drop after out_ready=1.
- In HOLD with 0x1234 pending, pulse bit_valid twice -> overrun=1, data_out stays 0x1234. Next accepted start -> overrun=0.
- Start, 7 bits of 1, then start again, then 16 bits of 0x00FF -> single word 0x00FF, no word for aborted frame, bit_count restarts at 0.
- rst asserted after 10 bits -> all outputs 0 next cycle. Subsequent start + 0xFFFF -> data_out=0xFFFF.
- PARITY_EN: word 0x0001 with parity bit 1 -> parity_err=0. Same word with parity bit 0 -> parity_err=1. Without macro, 16 bits suffice and parity_err=0.

Source files
------------

// File: rtl/serial_word_collector_if.sv
// serial_word_collector_if: word-level valid/ready output port of the serial collector
interface serial_word_collector_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] data_out;
  logic out_valid;
  logic out_ready;
  modport master (output data_out, out_valid, input out_ready);
  modport slave (input data_out, out_valid, output out_ready);
endinterface

// File: rtl/serial_word_collector.sv
// serial_word_collector: MSB-first serial-to-parallel receiver with valid/ready word output
// Optional even-parity bit per frame when PARITY_EN is defined.
module serial_word_collector #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic bit_in,
  serial_word_collector_if.master word,
  output logic busy,
  output logic [CNT_W-1:0] bit_count,
  output logic overrun,
  output logic parity_err
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, HOLD = 2'd3;
  logic [1:0] state;
  logic [WIDTH-1:0] shreg, data;
  logic valid;
  logic [WIDTH-1:0] nxt;
  assign nxt = {shreg[WIDTH-2:0], bit_in};
  assign busy = state == SHIFT || state == PARITY;
  assign word.data_out = data;
  assign word.out_valid = valid;
`ifdef PARITY_EN
  logic perr;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      data <= '0;
      valid <= 1'b0;
      bit_count <= '0;
      overrun <= 1'b0;
`ifdef PARITY_EN
      perr <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= SHIFT;
          shreg <= '0;
          bit_count <= '0;
          overrun <= 1'b0;
        end
        SHIFT: if (start) begin
          shreg <= '0;
          bit_count <= '0;
          overrun <= 1'b0;
        end else if (bit_valid) begin
          shreg <= nxt;
          bit_count <= bit_count + CNT_W'(1);
          if (bit_count == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_EN
            state <= PARITY;
`else
            state <= HOLD;
            data <= nxt;
            valid <= 1'b1;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: if (start) begin
          state <= SHIFT;
          shreg <= '0;
          bit_count <= '0;
          overrun <= 1'b0;
        end else if (bit_valid) begin
          state <= HOLD;
          data <= shreg;
          valid <= 1'b1;
          perr <= (^shreg) ^ bit_in;
        end
`endif
        HOLD: begin
          if (bit_valid) overrun <= 1'b1;
          if (word.out_ready) begin
            valid <= 1'b0;
`ifdef PARITY_EN
            perr <= 1'b0;
`endif
            state <= start ? SHIFT : IDLE;
            // an accepted start opens the next frame in the same cycle
            if (start) begin
              shreg <= '0;
              bit_count <= '0;
              overrun <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_word_collector.sv
// tb_serial_word_collector: directed self-checking bench for serial_word_collector
module tb_serial_word_collector;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, bit_valid = 1'b0, bit_in = 1'b0;
  logic busy, overrun, parity_err;
  logic [4:0] bit_count;
  int checks = 0, errors = 0;
  serial_word_collector_if #(.WIDTH(16)) w ();
  serial_word_collector #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .word(w), .busy(busy), .bit_count(bit_count), .overrun(overrun), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send_bits(input logic [15:0] v, input int n, input bit gap);
    for (int i = 15; i > 15 - n; i--) begin
      bit_valid = 1'b1;
      bit_in = v[i];
      tick;
      if (gap) begin
        bit_valid = 1'b0;
        tick;
      end
    end
    bit_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [15:0] v, input bit gap, input logic par);
    send_bits(v, 16, gap);
`ifdef PARITY_EN
    bit_valid = 1'b1;
    bit_in = par;
    tick;
    bit_valid = 1'b0;
`else
    if (par) bit_in = 1'b0;
`endif
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask
  initial begin
    w.out_ready = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_data", 32'(w.data_out), 32'h0);
    chk("rst_valid", 32'(w.out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(bit_count), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    // frame 1: back-to-back bits, consumer ready
    w.out_ready = 1'b1;
    pulse_start;
    chk("f1_busy", 32'(busy), 32'h1);
    chk("f1_count0", 32'(bit_count), 32'h0);
    send_frame(16'hA5C3, 1'b0, ^16'hA5C3);
    chk("f1_valid", 32'(w.out_valid), 32'h1);
    chk("f1_data", 32'(w.data_out), 32'hA5C3);
    chk("f1_count16", 32'(bit_count), 32'd16);
    chk("f1_busy_hold", 32'(busy), 32'h0);
    tick;
    chk("f1_accepted", 32'(w.out_valid), 32'h0);
    chk("f1_idle_busy", 32'(busy), 32'h0);
    // frame 2: gapped bits, consumer stalls
    w.out_ready = 1'b0;
    pulse_start;
    send_frame(16'h8001, 1'b1, ^16'h8001);
    chk("f2_valid", 32'(w.out_valid), 32'h1);
    chk("f2_data", 32'(w.data_out), 32'h8001);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("f2_hold_valid", 32'(w.out_valid), 32'h1);
      chk("f2_hold_data", 32'(w.data_out), 32'h8001);
    end
    w.out_ready = 1'b1;
    tick;
    chk("f2_drop", 32'(w.out_valid), 32'h0);
    // frame 3: overrun in HOLD, cleared by accepted start
    w.out_ready = 1'b0;
    pulse_start;
    send_frame(16'h1234, 1'b0, ^16'h1234);
    chk("f3_valid", 32'(w.out_valid), 32'h1);
    chk("f3_no_overrun", 32'(overrun), 32'h0);
    bit_in = 1'b1;
    bit_valid = 1'b1;
    tick;
    tick;
    bit_valid = 1'b0;
    chk("f3_overrun", 32'(overrun), 32'h1);
    chk("f3_data_kept", 32'(w.data_out), 32'h1234);
    chk("f3_valid_kept", 32'(w.out_valid), 32'h1);
    start = 1'b1;
    tick;
    chk("f3_start_ignored", 32'(w.out_valid), 32'h1);
    w.out_ready = 1'b1;
    tick;
    start = 1'b0;
    w.out_ready = 1'b0;
    chk("f3_accept", 32'(w.out_valid), 32'h0);
    chk("f3_overrun_clr", 32'(overrun), 32'h0);
    chk("f3_busy", 32'(busy), 32'h1);
    chk("f3_count0", 32'(bit_count), 32'h0);
    // frame 4: abort after 7 bits, restart with 0x00FF
    send_bits(16'hFE00, 7, 1'b0);
    chk("f4_count7", 32'(bit_count), 32'd7);
    bit_valid = 1'b1;
    bit_in = 1'b1;
    pulse_start;
    bit_valid = 1'b0;
    chk("f4_restart_count", 32'(bit_count), 32'h0);
    chk("f4_restart_busy", 32'(busy), 32'h1);
    send_bits(16'h00FF, 15, 1'b0);
    chk("f4_no_early_word", 32'(w.out_valid), 32'h0);
    chk("f4_count15", 32'(bit_count), 32'd15);
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick;
    bit_valid = 1'b0;
`ifdef PARITY_EN
    bit_valid = 1'b1;
    bit_in = 1'b0;
    tick;
    bit_valid = 1'b0;
`endif
    chk("f4_valid", 32'(w.out_valid), 32'h1);
    chk("f4_data", 32'(w.data_out), 32'h00FF);
    w.out_ready = 1'b1;
    tick;
    chk("f4_accept", 32'(w.out_valid), 32'h0);
    // frame 5: reset mid-frame, then 0xFFFF
    w.out_ready = 1'b0;
    pulse_start;
    send_bits(16'hFFC0, 10, 1'b0);
    chk("f5_count10", 32'(bit_count), 32'd10);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("f5_rst_busy", 32'(busy), 32'h0);
    chk("f5_rst_count", 32'(bit_count), 32'h0);
    chk("f5_rst_data", 32'(w.data_out), 32'h0);
    chk("f5_rst_valid", 32'(w.out_valid), 32'h0);
    pulse_start;
    send_frame(16'hFFFF, 1'b0, ^16'hFFFF);
    chk("f5_data", 32'(w.data_out), 32'hFFFF);
    chk("f5_valid", 32'(w.out_valid), 32'h1);
    chk("f5_perr", 32'(parity_err), 32'h0);
    w.out_ready = 1'b1;
    tick;
    chk("f5_accept", 32'(w.out_valid), 32'h0);
`ifdef PARITY_EN
    // parity: good then bad parity bit on 0x0001
    w.out_ready = 1'b0;
    pulse_start;
    send_frame(16'h0001, 1'b0, 1'b1);
    chk("p1_valid", 32'(w.out_valid), 32'h1);
    chk("p1_perr", 32'(parity_err), 32'h0);
    w.out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    w.out_ready = 1'b0;
    send_frame(16'h0001, 1'b0, 1'b0);
    chk("p2_data", 32'(w.data_out), 32'h0001);
    chk("p2_perr", 32'(parity_err), 32'h1);
    w.out_ready = 1'b1;
    tick;
    chk("p2_perr_clr", 32'(parity_err), 32'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
